// File: rtl/ei_axi4_pkg.sv
// ----------------------------------------------------------------------------
// ei_axi4_pkg
// Shared types for the AXI4 write-channel slave responder.
//   burst_e : AXI burst encodings (FIXED, INCR, WRAP, reserved)
//   state_e : write-slave FSM states
//   OKAY / SLVERR : B channel response codes
// No ports; imported by ei_axi4_addr_gen and ei_axi4_write_slave.
// ----------------------------------------------------------------------------
package ei_axi4_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2,
    RSVD  = 2'd3
  } burst_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/ei_axi4_addr_gen.sv
// ----------------------------------------------------------------------------
// ei_axi4_addr_gen
// Combinational AXI next-beat address calculator.
// Ports:
//   addr      in  32  address of the current beat
//   len       in  8   burst length minus 1
//   size      in  3   log2 of bytes per beat
//   burst     in  2   burst type (burst_e)
//   next_addr out 32  address of the following beat
// ----------------------------------------------------------------------------
module ei_axi4_addr_gen
  import ei_axi4_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [7:0]  len,
  input  logic [2:0]  size,
  input  burst_e      burst,
  output logic [31:0] next_addr
);

  logic [31:0] beat_bytes;
  logic [31:0] wrap_bytes;
  logic [31:0] wrap_base;

  // WRAP only ever sees legal lengths (1,3,7,15) on bursts that actually
  // write, so wrap_bytes is a power of two and the modulo reduces to a mask.
  // For illegal WRAP bursts the result is harmless because writes are
  // suppressed for the whole burst.
  always_comb begin
    beat_bytes = 32'd1 << size;
    wrap_bytes = ({24'd0, len} + 32'd1) << size;
    wrap_base  = addr & ~(wrap_bytes - 32'd1);
    next_addr  = addr;
    case (burst)
      INCR:    next_addr = (addr & ~(beat_bytes - 32'd1)) + beat_bytes;
      WRAP:    next_addr = wrap_base + ((addr + beat_bytes - wrap_base) & (wrap_bytes - 32'd1));
      default: next_addr = addr;
    endcase
  end

endmodule

// File: rtl/ei_axi4_write_slave.sv
// ----------------------------------------------------------------------------
// ei_axi4_write_slave
// AXI4 write-channel slave responder with an internal word memory. Accepts
// one AW burst at a time, stores strobed W beats, and returns one B response
// per burst. A combinational backdoor port exposes memory contents.
// Ports:
//   aclk, temp_aresetn          clock, asynchronous active-low reset
//   awaddr/awlen/awsize/awburst AW payload
//   awvalid/awready             AW handshake
//   wdata/wstrb/wlast           W payload
//   wvalid/wready               W handshake
//   bresp, bvalid/bready        B response and handshake
//   rd_addr/rd_data             backdoor word read (combinational)
// ----------------------------------------------------------------------------
module ei_axi4_write_slave
  import ei_axi4_pkg::*;
#(
  parameter int BUS_WIDTH      = 64,
  parameter int BUS_BYTE_LANES = BUS_WIDTH / 8,
  parameter int MEM_DEPTH      = 256
) (
  input  logic                          aclk,
  input  logic                          temp_aresetn,
  input  logic [31:0]                   awaddr,
  input  logic [7:0]                    awlen,
  input  logic [2:0]                    awsize,
  input  logic [1:0]                    awburst,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [BUS_WIDTH-1:0]          wdata,
  input  logic [BUS_BYTE_LANES-1:0]     wstrb,
  input  logic                          wlast,
  input  logic                          wvalid,
  output logic                          wready,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  input  logic [$clog2(MEM_DEPTH)-1:0]  rd_addr,
  output logic [BUS_WIDTH-1:0]          rd_data
);

  localparam int          LANE_LOG2 = $clog2(BUS_BYTE_LANES);
  localparam int          IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * BUS_BYTE_LANES);

  state_e      state;
  state_e      state_next;
  logic [31:0] addr;
  logic [31:0] addr_next;
  logic [7:0]  len;
  logic [2:0]  size;
  burst_e      burst;
  logic [7:0]  beat_cnt;
  logic        err;
  logic        err_next;
  logic        suppress;
  logic        aw_err;
  logic        in_range;
  logic        mem_we;

  logic [31:0] size_mask;
  logic [31:0] aligned_page;
  logic [31:0] burst_span;
  logic        wrap_len_ok;

  logic [BUS_WIDTH-1:0] mem [MEM_DEPTH];

  ei_axi4_addr_gen u_addr_gen (
    .addr      (addr),
    .len       (len),
    .size      (size),
    .burst     (burst),
    .next_addr (addr_next)
  );

  // Burst legality is judged once, on the incoming AW payload. Any failure
  // here blocks every memory write of the burst and forces SLVERR. The 4KB
  // check uses the size-aligned offset within the page, since an unaligned
  // INCR start only shortens the first beat.
  always_comb begin
    size_mask    = (32'd1 << awsize) - 32'd1;
    aligned_page = {20'd0, awaddr[11:0]} & ~size_mask;
    burst_span   = ({24'd0, awlen} + 32'd1) << awsize;
    wrap_len_ok  = (awlen == 8'd1) || (awlen == 8'd3) || (awlen == 8'd7) || (awlen == 8'd15);
    aw_err       = 1'b0;
    if (awburst == 2'd3) begin
      aw_err = 1'b1;
    end
    if ({29'd0, awsize} > 32'(LANE_LOG2)) begin
      aw_err = 1'b1;
    end
    if (burst_e'(awburst) == WRAP && (!wrap_len_ok || (awaddr & size_mask) != 32'd0)) begin
      aw_err = 1'b1;
    end
    if (burst_e'(awburst) == INCR && (aligned_page + burst_span) > 32'd4096) begin
      aw_err = 1'b1;
    end
  end

  assign in_range = addr < MEM_BYTES;

  // Next-state and sticky error decode. A premature wlast still closes the
  // burst; a missing wlast keeps the slave in DATA until wlast finally shows.
  always_comb begin
    state_next = state;
    err_next   = err;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (awvalid && awready) begin
          state_next = DATA;
          err_next   = aw_err;
        end
      end
      DATA: begin
        if (wvalid && wready) begin
          mem_we = !suppress && in_range;
          if (!in_range) begin
            err_next = 1'b1;
          end
          if (wlast) begin
            if (beat_cnt != len) begin
              err_next = 1'b1;
            end
            state_next = RESP;
          end else if (beat_cnt == len) begin
            err_next = 1'b1;
          end
        end
      end
      RESP: begin
        if (bvalid && bready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, burst context and the registered handshake outputs. The outputs
  // are decoded from state_next so they line up with the state they describe
  // from the very first cycle of that state.
  always_ff @(posedge aclk or negedge temp_aresetn) begin
    if (!temp_aresetn) begin
      state    <= IDLE;
      addr     <= 32'd0;
      len      <= 8'd0;
      size     <= 3'd0;
      burst    <= FIXED;
      beat_cnt <= 8'd0;
      err      <= 1'b0;
      suppress <= 1'b0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= OKAY;
    end else begin
      state   <= state_next;
      err     <= err_next;
      awready <= (state_next == IDLE);
      wready  <= (state_next == DATA);
      bvalid  <= (state_next == RESP);
      bresp   <= (state_next == RESP && err_next) ? SLVERR : OKAY;
      if (state == IDLE && awvalid && awready) begin
        addr     <= awaddr;
        len      <= awlen;
        size     <= awsize;
        burst    <= burst_e'(awburst);
        beat_cnt <= 8'd0;
        suppress <= aw_err;
      end else if (state == DATA && wvalid && wready) begin
        addr     <= addr_next;
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  // Word memory with per-byte enables. It is deliberately outside the reset
  // domain so contents survive a mid-burst reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < BUS_BYTE_LANES; i++) begin
        if (wstrb[i]) begin
          mem[addr[LANE_LOG2 +: IDX_W]][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule
